// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
// Module      : calc_engine
// Description : Calculator core. Two operands are entered on rising edges of
//               the progress button. The engine adds or subtracts them with
//               signed saturation, converts |result| to BCD (one double-dabble
//               step per clock) and scans the digits out one at a time for a
//               7-segment encoder.
//               Optional feature macro: CALC_CHAIN_EN. When it is defined, an
//               edge in SHOW loads the result back as op1 (accumulator chain).
//               When it is not defined, an edge in SHOW returns to OP1 with
//               op1 cleared.
// Ports       : clk, reset_n (async, active-low), clear (sync, active-high),
//               progress (button level), operand_in[WIDTH], op_sub,
//               state[2], result[ACC_W], overflow, is_negative, bcd_valid,
//               digit_sel[$clog2(NUM_DIGITS)], digit_val[4]
// Revision    : 1.0 - initial release
// ============================================================================
module calc_engine #(
    parameter int WIDTH      = 4,
    parameter int ACC_W      = 6,
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          clear,
    input  logic                          progress,
    input  logic [WIDTH-1:0]              operand_in,
    input  logic                          op_sub,
    output logic [1:0]                    state,
    output logic [ACC_W-1:0]              result,
    output logic                          overflow,
    output logic                          is_negative,
    output logic                          bcd_valid,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
    output logic [3:0]                    digit_val
);

    localparam logic [1:0] c_st_op1  = 2'b00;
    localparam logic [1:0] c_st_op2  = 2'b01;
    localparam logic [1:0] c_st_conv = 2'b10;
    localparam logic [1:0] c_st_show = 2'b11;

    // The top digit carries the sign, so only NUM_DIGITS-1 BCD digits exist.
    localparam int c_bcd_digits = NUM_DIGITS - 1;
    localparam int c_bcd_w      = 4 * c_bcd_digits;
    localparam int c_sel_w      = $clog2(NUM_DIGITS);
    localparam int c_cnt_w      = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam int c_scan_w     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(ACC_W - 1);
    localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(SCAN_DIV - 1);
    localparam logic [c_sel_w-1:0]  c_sel_last  = c_sel_w'(NUM_DIGITS - 1);

    // Saturation bounds expressed in the ACC_W+1 bit working width.
    localparam logic signed [ACC_W:0] c_max = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_min = {2'b11, {(ACC_W-1){1'b0}}};

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_progress_q;
    logic [ACC_W-1:0]    r_op1;
    logic [ACC_W-1:0]    r_result;
    logic                r_overflow;
    logic                r_bcd_valid;
    logic [ACC_W-1:0]    r_bin;
    logic [c_bcd_w-1:0]  r_bcd;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_scan_w-1:0] r_scan_cnt;
    logic [c_sel_w-1:0]  r_digit_sel;

    logic                     w_edge;
    logic signed [ACC_W:0]    w_op1_ext;
    logic signed [ACC_W:0]    w_op2_ext;
    logic signed [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]         w_sat_val;
    logic                     w_sat_ovf;
    logic [ACC_W-1:0]         w_sat_abs;
    logic [c_bcd_w-1:0]       w_bcd_adj;
    logic [NUM_DIGITS-1:0][3:0] w_digits;
    logic [3:0]               w_digit_val;

    assign w_edge = progress & ~r_progress_q;

    // op1 is signed (it can hold a chained negative result); op2 is unsigned.
    assign w_op1_ext = {r_op1[ACC_W-1], r_op1};
    assign w_op2_ext = {{(ACC_W+1-WIDTH){1'b0}}, operand_in};
    assign w_sum     = op_sub ? (w_op1_ext - w_op2_ext) : (w_op1_ext + w_op2_ext);

    always_comb begin
        w_sat_val = w_sum[ACC_W-1:0];
        w_sat_ovf = 1'b0;
        if (w_sum > c_max) begin
            w_sat_val = c_max[ACC_W-1:0];
            w_sat_ovf = 1'b1;
        end else if (w_sum < c_min) begin
            w_sat_val = c_min[ACC_W-1:0];
            w_sat_ovf = 1'b1;
        end
    end

    // |min| still fits in ACC_W unsigned bits, so no extra width is needed.
    assign w_sat_abs = w_sat_val[ACC_W-1] ? ((~w_sat_val) + {{(ACC_W-1){1'b0}}, 1'b1})
                                          : w_sat_val;

    // Double-dabble adjust: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < c_bcd_digits; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_op1;
        end else if (clear) begin
            r_state <= c_st_op1;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_op1:  if (w_edge) w_next_state = c_st_op2;
            c_st_op2:  if (w_edge) w_next_state = c_st_conv;
            c_st_conv: if (r_cnt == c_cnt_last) w_next_state = c_st_show;
            c_st_show: begin
                if (w_edge) begin
`ifdef CALC_CHAIN_EN
                    w_next_state = c_st_op2;
`else
                    w_next_state = c_st_op1;
`endif
                end
            end
            default:   w_next_state = c_st_op1;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, conversion and scan
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_progress_q <= 1'b1;
            r_op1        <= '0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
            r_bcd_valid  <= 1'b0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_scan_cnt   <= '0;
            r_digit_sel  <= '0;
        end else if (clear) begin
            r_progress_q <= 1'b1;
            r_op1        <= '0;
            r_result     <= '0;
            r_overflow   <= 1'b0;
            r_bcd_valid  <= 1'b0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_cnt        <= '0;
            r_scan_cnt   <= '0;
            r_digit_sel  <= '0;
        end else begin
            r_progress_q <= progress;

            if (r_scan_cnt == c_scan_last) begin
                r_scan_cnt  <= '0;
                r_digit_sel <= (r_digit_sel == c_sel_last) ? '0 : r_digit_sel + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            case (r_state)
                c_st_op1: begin
                    if (w_edge) begin
                        r_op1 <= {{(ACC_W-WIDTH){1'b0}}, operand_in};
                    end
                end
                c_st_op2: begin
                    if (w_edge) begin
                        r_result   <= w_sat_val;
                        r_overflow <= w_sat_ovf;
                        r_bin      <= w_sat_abs;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                    end
                end
                c_st_conv: begin
                    r_bcd <= (w_bcd_adj << 1) | {{(c_bcd_w-1){1'b0}}, r_bin[ACC_W-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_bcd_valid <= 1'b1;
                    end
                end
                c_st_show: begin
                    if (w_edge) begin
                        r_bcd_valid <= 1'b0;
`ifdef CALC_CHAIN_EN
                        r_op1 <= r_result;
`else
                        r_op1 <= '0;
`endif
                    end
                end
                default: begin
                    r_bcd_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit formatting: bcd_valid is high exactly while in SHOW, so it
    // gates every digit to blank in the other states.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i == NUM_DIGITS - 1) begin : g_sign
            assign w_digits[i] = (r_bcd_valid && r_result[ACC_W-1]) ? 4'hA : 4'hF;
        end else if (i == 0) begin : g_lsd
            assign w_digits[i] = r_bcd_valid ? r_bcd[3:0] : 4'hF;
        end else begin : g_upper
            // Blank when this digit and everything above it are zero.
            assign w_digits[i] = (r_bcd_valid && (|r_bcd[c_bcd_w-1:4*i])) ?
                                 r_bcd[4*i +: 4] : 4'hF;
        end
    end

    always_comb begin
        w_digit_val = 4'hF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_sel == c_sel_w'(i)) begin
                w_digit_val = w_digits[i];
            end
        end
    end

    assign state       = r_state;
    assign result      = r_result;
    assign overflow    = r_overflow;
    assign is_negative = r_result[ACC_W-1];
    assign bcd_valid   = r_bcd_valid;
    assign digit_sel   = r_digit_sel;
    assign digit_val   = w_digit_val;

endmodule
`default_nettype wire
